// File: rtl/kbest_pkg.sv
// rtl/kbest_pkg.sv - shared constants, state encoding and helpers for the K-best update sequencer
package kbest_pkg;
    localparam int ADDR_WIDTH  = 8;
    localparam int IDX_WIDTH   = 9;
    localparam int NUM_ENTRIES = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RD,
        S_MRG,
        S_WR
    } state_t;

    // "Empty" slot marker: the largest representable distance.
    function automatic logic [31:0] dist_max(input int width);
        return (32'd1 << width) - 32'd1;
    endfunction
endpackage

// File: rtl/kbest_insert.sv
// rtl/kbest_insert.sv - combinational sorted insert of one candidate into an ascending K-list
module kbest_insert
    import kbest_pkg::*;
#(
    parameter int DATA_WIDTH = 11,
    parameter int K          = 4
) (
    input  logic [DATA_WIDTH*K-1:0] i_dist,
    input  logic [IDX_WIDTH*K-1:0]  i_idx,
    input  logic [DATA_WIDTH-1:0]   i_cand_dist,
    input  logic [IDX_WIDTH-1:0]    i_cand_idx,
    output logic [DATA_WIDTH*K-1:0] o_dist,
    output logic [IDX_WIDTH*K-1:0]  o_idx,
    output logic                    o_insert
);
    // The list is sorted, so w_keep is a thermometer code: ones for slots ahead of the candidate.
    logic [K-1:0] w_keep;

    always_comb begin
        for (int j = 0; j < K; j++) begin
            w_keep[j] = (i_dist[j*DATA_WIDTH +: DATA_WIDTH] <= i_cand_dist);
        end
    end

    always_comb begin
        o_dist = i_dist;
        o_idx  = i_idx;
        if (!w_keep[0]) begin
            o_dist[0 +: DATA_WIDTH] = i_cand_dist;
            o_idx[0 +: IDX_WIDTH]   = i_cand_idx;
        end
        for (int j = 1; j < K; j++) begin
            if (!w_keep[j]) begin
                if (w_keep[j-1]) begin
                    o_dist[j*DATA_WIDTH +: DATA_WIDTH] = i_cand_dist;
                    o_idx[j*IDX_WIDTH +: IDX_WIDTH]    = i_cand_idx;
                end else begin
                    o_dist[j*DATA_WIDTH +: DATA_WIDTH] = i_dist[(j-1)*DATA_WIDTH +: DATA_WIDTH];
                    o_idx[j*IDX_WIDTH +: IDX_WIDTH]    = i_idx[(j-1)*IDX_WIDTH +: IDX_WIDTH];
                end
            end
        end
    end

    assign o_insert = !w_keep[K-1];
endmodule

// File: rtl/kbest_update_ctrl.sv
// rtl/kbest_update_ctrl.sv - init, read-merge-write insertion and readout sequencing for the K-best SRAM bank
module kbest_update_ctrl
    import kbest_pkg::*;
#(
    parameter int DATA_WIDTH = 11,
    parameter int K          = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    init_start,
    output logic                    busy,
    input  logic                    cand_valid,
    output logic                    cand_ready,
    input  logic [ADDR_WIDTH-1:0]   cand_addr,
    input  logic [DATA_WIDTH-1:0]   cand_dist,
    input  logic [IDX_WIDTH-1:0]    cand_idx,
    output logic                    csb0,
    output logic                    web0,
    output logic [ADDR_WIDTH-1:0]   addr0,
    output logic [DATA_WIDTH*K-1:0] wdist_0,
    output logic [IDX_WIDTH*K-1:0]  windices_0,
    input  logic [DATA_WIDTH*K-1:0] rdist_0,
    input  logic [IDX_WIDTH*K-1:0]  rindices_0,
    input  logic                    out_req_valid,
    input  logic [ADDR_WIDTH-1:0]   out_req_addr,
    output logic                    out_req_ready,
    output logic                    csb1,
    output logic [ADDR_WIDTH-1:0]   addr1,
    input  logic [DATA_WIDTH*K-1:0] rdist_1,
    input  logic [IDX_WIDTH*K-1:0]  rindices_1,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH*K-1:0] out_dist,
    output logic [IDX_WIDTH*K-1:0]  out_idx
);
    localparam logic [DATA_WIDTH-1:0] DIST_MAX = DATA_WIDTH'(dist_max(DATA_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ENTRIES - 1);

    state_t                  r_state, w_next;
    logic [ADDR_WIDTH-1:0]   r_init_cnt, r_addr;
    logic [DATA_WIDTH-1:0]   r_cand_dist;
    logic [IDX_WIDTH-1:0]    r_cand_idx;
    logic [DATA_WIDTH*K-1:0] r_mrg_dist, w_ins_dist, r_out_dist;
    logic [IDX_WIDTH*K-1:0]  r_mrg_idx, w_ins_idx, r_out_idx;
    logic                    w_insert, w_cand_hs, w_req_hs;
    logic                    r_rd_inflight, r_out_valid;

    kbest_insert #(.DATA_WIDTH(DATA_WIDTH), .K(K)) u_insert (
        .i_dist      (rdist_0),
        .i_idx       (rindices_0),
        .i_cand_dist (r_cand_dist),
        .i_cand_idx  (r_cand_idx),
        .o_dist      (w_ins_dist),
        .o_idx       (w_ins_idx),
        .o_insert    (w_insert)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_init_cnt  <= '0;
            r_addr      <= '0;
            r_cand_dist <= '0;
            r_cand_idx  <= '0;
            r_mrg_dist  <= '0;
            r_mrg_idx   <= '0;
        end else begin
            r_state <= w_next;
            // Wraps back to 0 after the last entry, ready for the next init.
            if (r_state == S_INIT) r_init_cnt <= r_init_cnt + 1'b1;
            if (w_cand_hs) begin
                r_addr      <= cand_addr;
                r_cand_dist <= cand_dist;
                r_cand_idx  <= cand_idx;
            end
            if (r_state == S_MRG) begin
                r_mrg_dist <= w_ins_dist;
                r_mrg_idx  <= w_ins_idx;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        cand_ready = 1'b0;
        w_cand_hs  = 1'b0;
        csb0       = 1'b1;
        web0       = 1'b1;
        addr0      = r_addr;
        wdist_0    = r_mrg_dist;
        windices_0 = r_mrg_idx;
        case (r_state)
            S_IDLE: begin
                cand_ready = !init_start;
                if (init_start) begin
                    w_next = S_INIT;
                end else if (cand_valid) begin
                    w_cand_hs = 1'b1;
                    w_next    = S_RD;
                end
            end
            S_INIT: begin
                csb0       = 1'b0;
                web0       = 1'b0;
                addr0      = r_init_cnt;
                wdist_0    = {K{DIST_MAX}};
                windices_0 = '0;
                if (r_init_cnt == LAST_ADDR) w_next = S_IDLE;
            end
            S_RD: begin
                csb0   = 1'b0;
                w_next = S_MRG;
            end
            S_MRG: begin
                w_next = w_insert ? S_WR : S_IDLE;
            end
            S_WR: begin
                csb0   = 1'b0;
                web0   = 1'b0;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign busy = (r_state != S_IDLE);

    // Readout shares no state with updates; it sees whatever port 1 returns, with no forwarding.
    assign out_req_ready = (r_state != S_INIT) && !r_rd_inflight && (!r_out_valid || out_ready);
    assign w_req_hs      = out_req_valid && out_req_ready;
    assign csb1          = !w_req_hs;
    assign addr1         = out_req_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_inflight <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_dist    <= '0;
            r_out_idx     <= '0;
        end else begin
            r_rd_inflight <= w_req_hs;
            if (r_rd_inflight) begin
                r_out_valid <= 1'b1;
                r_out_dist  <= rdist_1;
                r_out_idx   <= rindices_1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_dist  = r_out_dist;
    assign out_idx   = r_out_idx;
endmodule

// File: tb/tb_kbest_update_ctrl.sv
// tb/tb_kbest_update_ctrl.sv - self-checking bench for kbest_update_ctrl with SRAM model and list-level reference
module tb_kbest_update_ctrl;
    localparam int DW = 11;
    localparam int K  = 4;
    localparam int DK = DW * K;
    localparam int IK = 9 * K;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init_start = 1'b0, busy;
    logic cand_valid = 1'b0, cand_ready;
    logic [7:0] cand_addr = '0;
    logic [DW-1:0] cand_dist = '0;
    logic [8:0] cand_idx = '0;
    logic csb0, web0, csb1;
    logic [7:0] addr0, addr1;
    logic [DK-1:0] wdist_0, rdist_0, rdist_1, out_dist;
    logic [IK-1:0] windices_0, rindices_0, rindices_1, out_idx;
    logic out_req_valid = 1'b0, out_req_ready;
    logic [7:0] out_req_addr = '0;
    logic out_valid, out_ready = 1'b0;

    always #5 clk = ~clk;

    kbest_update_ctrl #(.DATA_WIDTH(DW), .K(K)) dut (
        .clk(clk), .rst_n(rst_n), .init_start(init_start), .busy(busy),
        .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_addr(cand_addr),
        .cand_dist(cand_dist), .cand_idx(cand_idx),
        .csb0(csb0), .web0(web0), .addr0(addr0), .wdist_0(wdist_0), .windices_0(windices_0),
        .rdist_0(rdist_0), .rindices_0(rindices_0),
        .out_req_valid(out_req_valid), .out_req_addr(out_req_addr), .out_req_ready(out_req_ready),
        .csb1(csb1), .addr1(addr1), .rdist_1(rdist_1), .rindices_1(rindices_1),
        .out_valid(out_valid), .out_ready(out_ready), .out_dist(out_dist), .out_idx(out_idx)
    );

    logic [DK-1:0] sram_d [256];
    logic [IK-1:0] sram_i [256];

    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) begin
                sram_d[addr0] <= wdist_0;
                sram_i[addr0] <= windices_0;
            end else begin
                rdist_0    <= sram_d[addr0];
                rindices_0 <= sram_i[addr0];
            end
        end
        if (!csb1) begin
            rdist_1    <= sram_d[addr1];
            rindices_1 <= sram_i[addr1];
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DK-1:0] lit_d(input int a0, input int a1, input int a2, input int a3);
        return {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
    endfunction

    function automatic logic [IK-1:0] lit_i(input int a0, input int a1, input int a2, input int a3);
        return {9'(a3), 9'(a2), 9'(a1), 9'(a0)};
    endfunction

    // Reference: list contents per address, plus cycle-level schedule of what port 0 must do.
    int gm_d [256][K];
    int gm_i [256][K];
    int c = 0;
    int m_free_at = 0, m_init_base = -1000, m_rd_cycle = -1, m_wr_cycle = -1;
    logic [7:0] m_addr = '0;
    logic [DK-1:0] m_wd = '0, m_od = '0, m_snap_d = '0;
    logic [IK-1:0] m_wi = '0, m_oi = '0, m_snap_i = '0;
    bit m_pend = 0, m_ov = 0;

    function automatic logic [DK-1:0] gm_pack_d(input int a);
        logic [DK-1:0] r;
        for (int j = 0; j < K; j++) r[j*DW +: DW] = DW'(gm_d[a][j]);
        return r;
    endfunction

    function automatic logic [IK-1:0] gm_pack_i(input int a);
        logic [IK-1:0] r;
        for (int j = 0; j < K; j++) r[j*9 +: 9] = 9'(gm_i[a][j]);
        return r;
    endfunction

    always @(negedge clk) begin : cmp_proc
        int off, pos;
        int md [K+1];
        int mi [K+1];
        bit in_init, idle, exp_rr, req_hs;
        if (!rst_n) begin
            m_free_at = 0; m_init_base = -1000; m_rd_cycle = -1; m_wr_cycle = -1;
            m_pend = 0; m_ov = 0; m_od = '0; m_oi = '0;
        end else begin
            off     = c - m_init_base;
            in_init = (off >= 0) && (off < 256);
            idle    = (c >= m_free_at);
            chk("busy", busy, !idle);
            chk("cand_ready", cand_ready, idle && !init_start);

            exp_rr = !in_init && !m_pend && (!m_ov || out_ready);
            req_hs = out_req_valid && exp_rr;
            chk("out_req_ready", out_req_ready, exp_rr);
            chk("out_valid", out_valid, m_ov);
            if (m_ov) begin
                chk("out_dist", out_dist, m_od);
                chk("out_idx", out_idx, m_oi);
            end
            chk("csb1", csb1, !req_hs);
            if (req_hs) chk("addr1", addr1, out_req_addr);
            if (m_pend) begin
                m_ov = 1; m_od = m_snap_d; m_oi = m_snap_i;
            end else if (m_ov && out_ready) begin
                m_ov = 0;
            end
            m_pend = req_hs;
            if (req_hs) begin
                m_snap_d = gm_pack_d(out_req_addr);
                m_snap_i = gm_pack_i(out_req_addr);
            end

            if (in_init) begin
                chk("init_cs_we", {csb0, web0}, 2'b00);
                chk("init_addr", addr0, off);
                chk("init_dist", wdist_0, {DK{1'b1}});
                chk("init_idx", windices_0, '0);
                for (int j = 0; j < K; j++) begin
                    gm_d[off][j] = 2047;
                    gm_i[off][j] = 0;
                end
            end else if (c == m_rd_cycle) begin
                chk("rd_cs_we", {csb0, web0}, 2'b01);
                chk("rd_addr", addr0, m_addr);
            end else if (c == m_wr_cycle) begin
                chk("wr_cs_we", {csb0, web0}, 2'b00);
                chk("wr_addr", addr0, m_addr);
                chk("wr_dist", wdist_0, m_wd);
                chk("wr_idx", windices_0, m_wi);
                for (int j = 0; j < K; j++) begin
                    gm_d[m_addr][j] = int'(m_wd[j*DW +: DW]);
                    gm_i[m_addr][j] = int'(m_wi[j*9 +: 9]);
                end
            end else begin
                chk("p0_quiet", {csb0, web0}, 2'b11);
            end

            if (idle && init_start) begin
                m_init_base = c + 1;
                m_free_at   = c + 257;
            end else if (idle && cand_valid) begin
                for (int j = 0; j < K; j++) begin
                    md[j] = gm_d[cand_addr][j];
                    mi[j] = gm_i[cand_addr][j];
                end
                // Walk the candidate up from the tail past strictly larger entries only.
                pos = K;
                while (pos > 0 && int'(cand_dist) < md[pos-1]) begin
                    md[pos] = md[pos-1];
                    mi[pos] = mi[pos-1];
                    pos--;
                end
                md[pos] = int'(cand_dist);
                mi[pos] = int'(cand_idx);
                m_addr = cand_addr;
                m_rd_cycle = c + 1;
                if (pos < K) begin
                    for (int j = 0; j < K; j++) begin
                        m_wd[j*DW +: DW] = DW'(md[j]);
                        m_wi[j*9 +: 9]   = 9'(mi[j]);
                    end
                    m_wr_cycle = c + 3;
                    m_free_at  = c + 4;
                end else begin
                    m_free_at = c + 3;
                end
            end
        end
        c++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cand(input logic [7:0] a, input int d, input int ix);
        int n;
        cand_valid = 1'b1; cand_addr = a; cand_dist = DW'(d); cand_idx = 9'(ix);
        n = 0;
        @(negedge clk);
        while (!cand_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("cand_hs_timeout", n < 50, 1);
        @(posedge clk);
        #1;
        cand_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic readout(input logic [7:0] a, output logic [DK-1:0] d, output logic [IK-1:0] i);
        int n;
        out_req_valid = 1'b1; out_req_addr = a; out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!out_req_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_req_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        chk("readout_timeout", out_valid, 1);
        d = out_dist;
        i = out_idx;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bd [4] = '{40, 30, 20, 10};
        int bi [4] = '{1, 2, 3, 4};
        logic [DK-1:0] rd;
        logic [IK-1:0] ri;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_csb0", csb0, 1);
        chk("rst_web0", web0, 1);
        chk("rst_csb1", csb1, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_dist", out_dist, 0);
        chk("rst_out_idx", out_idx, 0);
        rst_n = 1'b1;
        tick();

        init_start = 1'b1; cand_valid = 1'b1; cand_addr = 8'd3; cand_dist = 11'd1; cand_idx = 9'd1;
        #1;
        chk("init_prio_ready", cand_ready, 0);
        tick();
        init_start = 1'b0; cand_valid = 1'b0;
        n = 0;
        while (busy && n < 400) begin
            n++;
            init_start = (n == 100);
            tick();
        end
        init_start = 1'b0;
        chk("init_busy_cycles", n, 256);

        send_cand(8'd5, 100, 7);
        chk("lat_rd", {csb0, web0}, 2'b01);
        tick();
        chk("lat_mrg", {csb0, web0}, 2'b11);
        tick();
        chk("lat_wr", {csb0, web0}, 2'b00);
        chk("lat_wr_addr", addr0, 5);
        chk("lat_wr_dist", wdist_0, lit_d(100, 2047, 2047, 2047));
        chk("lat_wr_idx", windices_0, lit_i(7, 0, 0, 0));
        tick();
        chk("ready_after_wr", cand_ready, 1);

        for (int k = 0; k < 4; k++) begin
            send_cand(8'd9, bd[k], bi[k]);
            wait_idle();
        end

        send_cand(8'd9, 40, 5);
        tick();
        tick();
        chk("reject_ready_3cyc", cand_ready, 1);
        chk("reject_no_write", {csb0, web0}, 2'b11);
        readout(8'd9, rd, ri);
        chk("list9_dist", rd, lit_d(10, 20, 30, 40));
        chk("list9_idx", ri, lit_i(4, 3, 2, 1));

        send_cand(8'd9, 20, 9);
        wait_idle();
        readout(8'd9, rd, ri);
        chk("tie_dist", rd, lit_d(10, 20, 20, 30));
        chk("tie_idx", ri, lit_i(4, 3, 9, 2));
        readout(8'd5, rd, ri);
        chk("list5_dist", rd, lit_d(100, 2047, 2047, 2047));

        out_ready = 1'b0; out_req_valid = 1'b1; out_req_addr = 8'd5;
        tick();
        out_req_addr = 8'd9;
        repeat (4) begin
            tick();
            chk("bp_blocked", out_req_ready, 0);
        end
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_dist", out_dist, lit_d(100, 2047, 2047, 2047));
        out_ready = 1'b1;
        #1;
        chk("bp_release", out_req_ready, 1);
        tick();
        out_req_valid = 1'b0;
        chk("bp_valid_drop", out_valid, 0);
        tick();
        chk("bp_second_valid", out_valid, 1);
        chk("bp_second_dist", out_dist, lit_d(10, 20, 20, 30));
        tick();

        out_ready = 1'b0; out_req_valid = 1'b1; out_req_addr = 8'd9;
        tick();
        out_req_valid = 1'b0;
        tick();
        chk("pre_rst_valid", out_valid, 1);
        send_cand(8'd5, 50, 3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_csb0", csb0, 1);
        chk("arst_web0", web0, 1);
        chk("arst_busy", busy, 0);
        chk("arst_out_valid", out_valid, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        readout(8'd5, rd, ri);
        chk("arst_no_write", rd, lit_d(100, 2047, 2047, 2047));
        chk("arst_no_write_idx", ri, lit_i(7, 0, 0, 0));

        send_cand(8'd5, 50, 3);
        wait_idle();
        readout(8'd5, rd, ri);
        chk("post_rst_dist", rd, lit_d(50, 100, 2047, 2047));
        chk("post_rst_idx", ri, lit_i(3, 7, 0, 0));

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
